// File: rtl/ikaopll_mixer.sv
// ikaopll_mixer
//   Output mixer behind the operator DAC. Sums the per-slot signed melodic and
//   rhythm impulses over one sample frame (frame edge = slot edge with
//   i_CYCLE_00 high), saturates each frame total to 16 bits, optionally
//   DC-blocks it, and queues it in a small FIFO drained by valid/ready.
//
//   Build option: define IKAOPLL_MIXER_DCBLOCK_EN to insert the DC-blocker
//   stage (adds one edge of latency). Without it the saturated frame total is
//   written straight into the FIFO.
//
// Ports
//   i_EMUCLK             master clock, all state on its rising edge
//   i_RST                synchronous active-high reset
//   i_phi1_NCEN_n        slot-rate enable, active low
//   i_CYCLE_00           frame-boundary marker (valid on slot edges only)
//   i_IMP_FLUC_SIGNED_MO signed melodic impulse for the current slot
//   i_IMP_FLUC_SIGNED_RO signed rhythm impulse for the current slot
//   o_SAMPLE             head-of-FIFO sample (last popped value when empty)
//   o_VALID              FIFO not empty
//   i_READY              consumer accepts o_SAMPLE when o_VALID is high
//   o_FIFO_LEVEL         FIFO occupancy, 0..FIFO_DEPTH
//   o_CLIP               sticky, a sample was saturated
//   o_OVERRUN            sticky, a sample was dropped on a full FIFO
module ikaopll_mixer #(
   parameter int FIFO_DEPTH = 4,
   parameter int MO_SHIFT   = 0,
   parameter int RO_SHIFT   = 1
) (
   input  logic               i_EMUCLK,
   input  logic               i_RST,
   input  logic               i_phi1_NCEN_n,
   input  logic               i_CYCLE_00,
   input  logic signed [9:0]  i_IMP_FLUC_SIGNED_MO,
   input  logic signed [9:0]  i_IMP_FLUC_SIGNED_RO,
   output logic signed [15:0] o_SAMPLE,
   output logic               o_VALID,
   input  logic               i_READY,
   output logic        [4:0]  o_FIFO_LEVEL,
   output logic               o_CLIP,
   output logic               o_OVERRUN
);
   localparam int         PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [4:0] FULL_LEVEL = 5'(FIFO_DEPTH);

   // ---------------------------------------------------------------- accumulate
   logic               slot_edge, boundary;
   logic signed [20:0] mo_ext, ro_ext, slot_in;
   logic signed [20:0] acc, tot_q;
   logic               armed, tot_vld;

   assign slot_edge = ~i_phi1_NCEN_n;
   assign boundary  = slot_edge & i_CYCLE_00;
   assign mo_ext    = {{11{i_IMP_FLUC_SIGNED_MO[9]}}, i_IMP_FLUC_SIGNED_MO};
   assign ro_ext    = {{11{i_IMP_FLUC_SIGNED_RO[9]}}, i_IMP_FLUC_SIGNED_RO};
   assign slot_in   = (mo_ext <<< MO_SHIFT) + (ro_ext <<< RO_SHIFT);

   always_ff @(posedge i_EMUCLK) begin
      if (i_RST) begin
         acc     <= '0;
         tot_q   <= '0;
         armed   <= 1'b0;
         tot_vld <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge value of acc; the frame total must not see this edge's input.
         tot_vld <= boundary & armed;
         if (boundary) begin
            tot_q <= acc;
            acc   <= slot_in;      // this edge's input opens the new frame
            armed <= 1'b1;         // first boundary only arms; partial frame dropped
         end else if (slot_edge) begin
            acc <= acc + slot_in;
         end
      end
   end

   // ---------------------------------------------------------------- saturate
   logic signed [15:0] sat_val;
   logic               sat_clip;

   always_comb begin
      // NOTE: defaults first so no path leaves a variable unassigned (no latch).
      sat_val  = tot_q[15:0];
      sat_clip = 1'b0;
      if (tot_q > 21'sd32767) begin
         sat_val  = 16'sh7fff;
         sat_clip = 1'b1;
      end else if (tot_q < -21'sd32768) begin
         sat_val  = 16'sh8000;
         sat_clip = 1'b1;
      end
   end

   // ---------------------------------------------------------------- DC blocker
   logic               push, push_clip;
   logic signed [15:0] push_data;

`ifdef IKAOPLL_MIXER_DCBLOCK_EN
   logic signed [15:0] x_prev, y_prev, dc_q, dc_y;
   logic signed [23:0] dc_sum;
   logic               dc_ovf, dc_vld, dc_clip_q;

   // y = x - x_prev + y_prev - (y_prev >>> 8), widened so no intermediate wraps
   always_comb begin
      dc_sum = 24'(sat_val) - 24'(x_prev) + 24'(y_prev) - (24'(y_prev) >>> 8);
      dc_y   = dc_sum[15:0];
      dc_ovf = 1'b0;
      if (dc_sum > 24'sd32767) begin
         dc_y   = 16'sh7fff;
         dc_ovf = 1'b1;
      end else if (dc_sum < -24'sd32768) begin
         dc_y   = 16'sh8000;
         dc_ovf = 1'b1;
      end
   end

   always_ff @(posedge i_EMUCLK) begin
      if (i_RST) begin
         x_prev    <= '0;
         y_prev    <= '0;
         dc_q      <= '0;
         dc_vld    <= 1'b0;
         dc_clip_q <= 1'b0;
      end else begin
         dc_vld <= tot_vld;
         if (tot_vld) begin
            dc_q      <= dc_y;
            dc_clip_q <= sat_clip | dc_ovf;   // clip reported when the sample lands
            x_prev    <= sat_val;
            y_prev    <= dc_y;
         end
      end
   end

   assign push      = dc_vld;
   assign push_data = dc_q;
   assign push_clip = dc_clip_q;
`else
   assign push      = tot_vld;
   assign push_data = sat_val;
   assign push_clip = sat_clip;
`endif

   // ---------------------------------------------------------------- FIFO
   logic signed [15:0] mem [FIFO_DEPTH];
   logic [PW-1:0]      rd_ptr, wr_ptr, rd_ptr_inc;
   logic [4:0]         level, level_nxt;
   logic               pop, full, do_push, drop;
   logic signed [15:0] head_nxt;

   assign rd_ptr_inc   = rd_ptr + PW'(1);
   assign pop          = o_VALID & i_READY;
   assign full         = (level == FULL_LEVEL);
   assign do_push      = push & (~full | pop);   // a pop frees the slot this edge
   assign drop         = push & full & ~pop;
   assign o_FIFO_LEVEL = level;

   // o_SAMPLE is registered, so the head after this edge is computed here:
   // pop first, then push, then level.
   always_comb begin
      level_nxt = level;
      if (pop)     level_nxt = level_nxt - 5'd1;
      if (do_push) level_nxt = level_nxt + 5'd1;
      head_nxt = o_SAMPLE;
      if (pop && (level > 5'd1))
         head_nxt = mem[rd_ptr_inc];
      else if (do_push && ((level == 5'd0) || pop))
         head_nxt = push_data;           // new entry becomes the head
   end

   // NOTE: storage is deliberately not reset; pointers and level define what
   // is valid, and leaving the array out of reset keeps it a plain RAM.
   always_ff @(posedge i_EMUCLK) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge i_EMUCLK) begin
      if (i_RST) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         level     <= '0;
         o_VALID   <= 1'b0;
         o_SAMPLE  <= '0;
         o_CLIP    <= 1'b0;
         o_OVERRUN <= 1'b0;
      end else begin
         if (pop)     rd_ptr <= rd_ptr_inc;
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         level    <= level_nxt;
         o_VALID  <= (level_nxt != 5'd0);
         o_SAMPLE <= head_nxt;
         if (push && push_clip) o_CLIP    <= 1'b1;
         if (drop)              o_OVERRUN <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ikaopll_mixer.sv
// Directed bench for ikaopll_mixer (FIFO_DEPTH=4, MO_SHIFT=0, RO_SHIFT=1).
// Frame totals are hand-computed; a small reference of the saturate/DC
// arithmetic turns them into expected FIFO samples for either build.
module tb_ikaopll_mixer;
`ifdef IKAOPLL_MIXER_DCBLOCK_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic               clk    = 1'b0;
   logic               rst    = 1'b1;
   logic               ncen_n = 1'b1;
   logic               c00    = 1'b0;
   logic               ready  = 1'b0;
   logic signed [9:0]  mo     = '0;
   logic signed [9:0]  ro     = '0;
   logic signed [15:0] sample;
   logic               valid, clip, overrun;
   logic [4:0]         level;

   int total = 0;
   int bad   = 0;
   int xp    = 0;
   int yp    = 0;
   bit clip_exp = 1'b0;
   int exp_q[$];

   ikaopll_mixer #(.FIFO_DEPTH(4), .MO_SHIFT(0), .RO_SHIFT(1)) dut (
      .i_EMUCLK            (clk),
      .i_RST               (rst),
      .i_phi1_NCEN_n       (ncen_n),
      .i_CYCLE_00          (c00),
      .i_IMP_FLUC_SIGNED_MO(mo),
      .i_IMP_FLUC_SIGNED_RO(ro),
      .o_SAMPLE            (sample),
      .o_VALID             (valid),
      .i_READY             (ready),
      .o_FIFO_LEVEL        (level),
      .o_CLIP              (clip),
      .o_OVERRUN           (overrun)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic model_reset();
      xp = 0;
      yp = 0;
      clip_exp = 1'b0;
      exp_q.delete();
   endtask

   // Expected FIFO value for one produced frame total.
   task automatic model_frame(input int tot);
      int x;
      int y;
      x = tot;
      if (x > 32767) begin x = 32767; clip_exp = 1'b1; end
      else if (x < -32768) begin x = -32768; clip_exp = 1'b1; end
`ifdef IKAOPLL_MIXER_DCBLOCK_EN
      y = x - xp + yp - (yp >>> 8);
      if (y > 32767) begin y = 32767; clip_exp = 1'b1; end
      else if (y < -32768) begin y = -32768; clip_exp = 1'b1; end
      xp = x;
      yp = y;
      x  = y;
`endif
      exp_q.push_back(x);
   endtask

   task automatic do_reset();
      rst = 1'b1; ncen_n = 1'b1; c00 = 1'b0; ready = 1'b0; mo = '0; ro = '0;
      tick(2);
      rst = 1'b0;
      model_reset();
   endtask

   // One boundary slot edge with zero input, so the new frame starts at 0.
   task automatic boundary();
      mo = '0; ro = '0; c00 = 1'b1; ncen_n = 1'b0;
      tick();
      ncen_n = 1'b1; c00 = 1'b0;
   endtask

   // n slot edges, each followed by a gated edge with the same inputs held.
   task automatic slots(input logic signed [9:0] m, input logic signed [9:0] r, input int n);
      for (int i = 0; i < n; i++) begin
         mo = m; ro = r; ncen_n = 1'b0;
         tick();
         ncen_n = 1'b1;
         tick();
      end
      mo = '0; ro = '0;
   endtask

   task automatic pop_one();
      ready = 1'b1;
      tick();
      ready = 1'b0;
      void'(exp_q.pop_front());
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (sample !== 16'sd0) begin bad++; $display("FAIL reset_sample: got %0d want 0", sample); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
      total++; if (level !== 5'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
      total++; if (clip !== 1'b0) begin bad++; $display("FAIL reset_clip: got %b want 0", clip); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
   endtask

   task automatic test_melodic();
      logic signed [15:0] popped;
      boundary();
      tick(LAT + 2);
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL arm_only_valid: got %b want 0", valid); end
      slots(10'sd100, 10'sd0, 18);
      boundary();
      model_frame(1800);
      tick(LAT - 1);
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL mo_valid_early: got %b want 0", valid); end
      tick();
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL mo_valid: got %b want 1", valid); end
      total++; if (level !== 5'd1) begin bad++; $display("FAIL mo_level: got %0d want 1", level); end
      total++; if (sample !== 16'(exp_q[0])) begin bad++; $display("FAIL mo_sample: got %0d want %0d", sample, exp_q[0]); end
      total++; if (clip !== 1'b0) begin bad++; $display("FAIL mo_clip: got %b want 0", clip); end
      popped = 16'(exp_q[0]);
      pop_one();
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL mo_empty_valid: got %b want 0", valid); end
      total++; if (sample !== popped) begin bad++; $display("FAIL mo_hold_sample: got %0d want %0d", sample, popped); end
   endtask

   task automatic test_rhythm();
      slots(10'sd0, -10'sd512, 18);
      boundary();
      model_frame(-18432);
      tick(LAT);
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL ro_valid: got %b want 1", valid); end
      total++; if (sample !== 16'(exp_q[0])) begin bad++; $display("FAIL ro_sample: got %0d want %0d", sample, exp_q[0]); end
      total++; if (clip !== clip_exp) begin bad++; $display("FAIL ro_clip: got %b want %b", clip, clip_exp); end
      pop_one();
   endtask

   task automatic test_clip();
      slots(10'sd511, 10'sd511, 22);          // 22 * 1533 = 33726
      boundary();
      model_frame(33726);
      tick(LAT);
      total++; if (sample !== 16'(exp_q[0])) begin bad++; $display("FAIL clip_pos_sample: got %0d want %0d", sample, exp_q[0]); end
      total++; if (clip !== 1'b1) begin bad++; $display("FAIL clip_pos_flag: got %b want 1", clip); end
      pop_one();
      slots(-10'sd512, -10'sd512, 22);        // 22 * -1536 = -33792
      boundary();
      model_frame(-33792);
      tick(LAT);
      total++; if (sample !== 16'(exp_q[0])) begin bad++; $display("FAIL clip_neg_sample: got %0d want %0d", sample, exp_q[0]); end
      pop_one();
      slots(10'sd10, 10'sd0, 3);
      boundary();
      model_frame(30);
      tick(LAT);
      total++; if (sample !== 16'(exp_q[0])) begin bad++; $display("FAIL clip_clean_sample: got %0d want %0d", sample, exp_q[0]); end
      total++; if (clip !== 1'b1) begin bad++; $display("FAIL clip_sticky: got %b want 1", clip); end
      pop_one();
   endtask

   task automatic test_overrun();
      do_reset();
      boundary();
      for (int k = 1; k <= 5; k++) begin
         slots(10'(k), 10'sd0, 1);
         boundary();
         model_frame(k);
         tick(LAT);
         if (k == 4) begin
            total++; if (level !== 5'd4) begin bad++; $display("FAIL ovr_level_full: got %0d want 4", level); end
            total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_flag_early: got %b want 0", overrun); end
         end
      end
      total++; if (level !== 5'd4) begin bad++; $display("FAIL ovr_level: got %0d want 4", level); end
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %b want 1", overrun); end
      for (int i = 0; i < 4; i++) begin
         total++; if (valid !== 1'b1 || sample !== 16'(exp_q[0])) begin
            bad++; $display("FAIL ovr_drain%0d: got valid=%b sample=%0d want valid=1 sample=%0d", i, valid, sample, exp_q[0]);
         end
         pop_one();
      end
      total++; if (valid !== 1'b0 || level !== 5'd0) begin
         bad++; $display("FAIL ovr_fifth_absent: got valid=%b level=%0d want 0 0", valid, level);
      end
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      do_reset();
      boundary();
      slots(10'sd7, 10'sd0, 1);
      boundary();
      model_frame(7);
      tick(LAT);
      slots(10'sd9, 10'sd0, 1);
      boundary();
      model_frame(9);
      tick(LAT - 1);
      pop_one();                              // pop lands on the push edge
      total++; if (level !== 5'd1) begin bad++; $display("FAIL b2b_lvl1_level: got %0d want 1", level); end
      total++; if (sample !== 16'(exp_q[0])) begin bad++; $display("FAIL b2b_lvl1_sample: got %0d want %0d", sample, exp_q[0]); end
      for (int k = 0; k < 3; k++) begin
         slots(10'(11 + 2 * k), 10'sd0, 1);
         boundary();
         model_frame(11 + 2 * k);
         tick(LAT);
      end
      total++; if (level !== 5'd4) begin bad++; $display("FAIL b2b_fill_level: got %0d want 4", level); end
      slots(10'sd17, 10'sd0, 1);
      boundary();
      model_frame(17);
      tick(LAT - 1);
      pop_one();
      total++; if (level !== 5'd4) begin bad++; $display("FAIL b2b_full_level: got %0d want 4", level); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_full_overrun: got %b want 0", overrun); end
      for (int i = 0; i < 4; i++) begin
         total++; if (valid !== 1'b1 || sample !== 16'(exp_q[0])) begin
            bad++; $display("FAIL b2b_drain%0d: got valid=%b sample=%0d want valid=1 sample=%0d", i, valid, sample, exp_q[0]);
         end
         pop_one();
      end
   endtask

`ifdef IKAOPLL_MIXER_DCBLOCK_EN
   task automatic test_dc();
      int want[3] = '{1800, 1793, 1786};
      do_reset();
      boundary();
      for (int k = 0; k < 3; k++) begin
         slots(10'sd100, 10'sd0, 18);
         boundary();
      end
      tick(LAT);
      total++; if (level !== 5'd3) begin bad++; $display("FAIL dc_level: got %0d want 3", level); end
      for (int i = 0; i < 3; i++) begin
         total++; if (sample !== 16'(want[i])) begin bad++; $display("FAIL dc_out%0d: got %0d want %0d", i, sample, want[i]); end
         ready = 1'b1; tick(); ready = 1'b0;
      end
      model_reset();
   endtask
`endif

   task automatic test_reset_mid();
      do_reset();
      boundary();
      slots(10'sd511, 10'sd511, 22);
      boundary();
      tick(LAT);
      slots(10'sd100, 10'sd0, 5);
      boundary();                             // frame in flight
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      total++; if (sample !== 16'sd0 || valid !== 1'b0 || level !== 5'd0) begin
         bad++; $display("FAIL mid_rst_fifo: got sample=%0d valid=%b level=%0d want 0 0 0", sample, valid, level);
      end
      total++; if (clip !== 1'b0 || overrun !== 1'b0) begin
         bad++; $display("FAIL mid_rst_flags: got clip=%b overrun=%b want 0 0", clip, overrun);
      end
      tick(LAT + 2);
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL mid_inflight: got %b want 0", valid); end
      slots(10'sd100, 10'sd0, 5);
      boundary();
      tick(LAT + 2);
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL mid_rearm: got %b want 0", valid); end
      slots(10'sd100, 10'sd0, 18);
      boundary();
      model_frame(1800);
      tick(LAT);
      total++; if (valid !== 1'b1 || sample !== 16'(exp_q[0])) begin
         bad++; $display("FAIL mid_first_sample: got valid=%b sample=%0d want valid=1 sample=%0d", valid, sample, exp_q[0]);
      end
   endtask

   initial begin
      test_reset();
      test_melodic();
      test_rhythm();
      test_clip();
      test_overrun();
      test_back_to_back();
`ifdef IKAOPLL_MIXER_DCBLOCK_EN
      test_dc();
`endif
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
